sbox_word_arbiter: RTL and testbench
====================================

Name: sbox_word_arbiter

Overview:
- Shares one registered S-box lookup (1-cycle latency, 8-bit in/out) between two 32-bit SubWord requesters: requester 0 is the key-expansion unit, requester 1 is the round datapath.
- Each accepted word is serialized byte-by-byte through the single S-box instance, reassembled, and returned to the requester that issued it.
- The block instantiates the team's sbox module internally; no other unit drives that instance.

Parameters:
FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins a tie.

Ports:
clk  in  1  single clock; all logic on posedge.
rst  in  1  synchronous reset, active-high.
req0_valid  in  1  requester 0 has a word pending.
req0_word  in  32  requester 0 input word; byte 0 = bits [7:0].
req0_ready  out  1  grant/accept to requester 0; transfer occurs when valid && ready in the same cycle.
rsp0_valid  out  1  one-cycle pulse: rsp0_word holds a new result.
rsp0_word  out  32  substituted word for requester 0.
req1_valid  in  1  as req0_valid, for requester 1.
req1_word  in  32  as req0_word, for requester 1.
req1_ready  out  1  as req0_ready, for requester 1.
rsp1_valid  out  1  as rsp0_valid, for requester 1.
rsp1_word  out  32  as rsp0_word, for requester 1.
busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: FSM = IDLE, byte index = 0, last_grant = 1 (requester 0 wins the first tie), hold/result registers = 0.
- Reset values of outputs: rsp*_valid = 0, rsp*_word = 0, req*_ready = 0, busy = 0.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE, grant logic:
  - req*_ready is combinational.
  - Only one valid: that requester gets ready.
  - Both valid, FIXED_PRIO=0: grant goes to !last_grant.
  - Both valid, FIXED_PRIO=1: grant always goes to requester 0.
  - Never both ready in the same cycle; ready = 0 in every state except IDLE.
- IDLE, on transfer: capture the word into the hold register, record owner, set last_grant = owner, index = 0, go to ISSUE.
- Requester rules: once valid is raised, it must hold valid and the word stable until ready. Dropping valid before ready is legal and means nothing is transferred.
- ISSUE:
  - The sbox input is hold[8*idx+7 : 8*idx]; idx runs 0,1,2,3 on consecutive cycles.
  - The sbox output for idx k appears in the next cycle and is written to result[8*k+7 : 8*k].
  - After idx 3, go to DRAIN.
- DRAIN: capture byte 3 into result[31:24], then go to IDLE. In the same edge, register rsp<owner>_valid = 1 and rsp<owner>_word = full result.
- Latency: transfer in cycle T gives rsp valid in cycle T+6, high for exactly one cycle.
- Throughput: the FSM is back in IDLE at T+6 and can accept a new word in that same cycle, so one word per 6 cycles.
- rsp*_word holds its last value until that requester's next response. The other requester's rsp word and valid are untouched.
- Responses have no backpressure; the requester must consume the pulse.
- Reset asserted mid-operation: the in-flight word is aborted, no response is issued, all state returns to reset values on the next edge.
- rsp*_valid is never asserted without a prior accepted transfer.

Test Plan:
- Single request: req0_word=0x00010203 held valid -> req0_ready in cycle T, rsp0_valid one cycle at T+6, rsp0_word=0x637C777B; busy high T+1..T+5.
- Data check: req1_word=0x53FF1000 -> rsp1_word=0xED16CA63; rsp0_word unchanged.
- Tie, FIXED_PRIO=0: both valid and held after reset -> grants alternate 0,1,0,1 at 6-cycle spacing, each rsp on the correct port with the correct word.
- Tie, FIXED_PRIO=1: both valid continuously -> only requester 0 is granted while its valid stays high; requester 1 is granted in the first IDLE cycle where req0_valid = 0.
- Back-to-back on one port: req0 valid continuously with new words -> accepts at T, T+6, T+12; each rsp0 pulse coincides with the next accept.
- Reset mid-op: rst pulsed at T+3 after accept -> no rsp pulse; busy=0 and ready available the cycle after rst deasserts; requester 0 wins the next tie.

Source files
------------

// File: rtl/sbox_word_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : sbox_word_arbiter_if
// Brief   : Request/response bundle between two SubWord requesters and the
//           shared S-box arbiter.
// Rev     : 1.0
// ============================================================================
interface sbox_word_arbiter_if;
   logic        req0_valid;
   logic [31:0] req0_word;
   logic        req0_ready;
   logic        rsp0_valid;
   logic [31:0] rsp0_word;
   logic        req1_valid;
   logic [31:0] req1_word;
   logic        req1_ready;
   logic        rsp1_valid;
   logic [31:0] rsp1_word;

   modport slave (
      input  req0_valid, req0_word, req1_valid, req1_word,
      output req0_ready, rsp0_valid, rsp0_word,
      output req1_ready, rsp1_valid, rsp1_word
   );

   modport master (
      output req0_valid, req0_word, req1_valid, req1_word,
      input  req0_ready, rsp0_valid, rsp0_word,
      input  req1_ready, rsp1_valid, rsp1_word
   );
endinterface
`default_nettype wire

// File: rtl/sbox_word_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sbox / sbox_word_arbiter
// Brief   : Registered AES S-box, and an arbiter that serialises 32-bit
//           SubWord requests from two requesters through that single S-box.
// Rev     : 1.0
// ============================================================================
module sbox (
   input  wire logic       clk,
   input  wire logic [7:0] i_data,
   output logic      [7:0] o_data
);
   // Entry 0 sits in the top byte, so entry n lives at byte position 255-n.
   localparam logic [2047:0] c_SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [7:0] r_data;

   always_ff @(posedge clk) begin
      r_data <= c_SBOX_TABLE[{~i_data, 3'b000} +: 8];
   end

   assign o_data = r_data;
endmodule

module sbox_word_arbiter #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  wire logic             clk,
   input  wire logic             rst,
   sbox_word_arbiter_if.slave    bus,
   output logic                  busy
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [1:0]  r_idx;
   logic        r_last_grant;
   logic        r_owner;
   logic [31:0] r_hold;
   logic [23:0] r_result;
   logic        r_rsp0_valid;
   logic [31:0] r_rsp0_word;
   logic        r_rsp1_valid;
   logic [31:0] r_rsp1_word;

   logic        w_grant1;
   logic        w_rdy0;
   logic        w_rdy1;
   logic        w_accept;
   logic [7:0]  w_sbox_in;
   logic [7:0]  w_sbox_out;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_grant1     = 1'b0;
      w_rdy0       = 1'b0;
      w_rdy1       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.req0_valid && bus.req1_valid)
               w_grant1 = FIXED_PRIO ? 1'b0 : ~r_last_grant;
            else
               w_grant1 = bus.req1_valid;
            w_rdy0 = bus.req0_valid && !w_grant1;
            w_rdy1 = bus.req1_valid && w_grant1;
            if (w_rdy0 || w_rdy1) w_next_state = S_ISSUE;
         end
         S_ISSUE: if (r_idx == 2'd3) w_next_state = S_DRAIN;
         S_DRAIN: w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   assign w_accept  = w_rdy0 || w_rdy1;
   assign w_sbox_in = r_hold[{r_idx, 3'b000} +: 8];

   sbox u_sbox (
      .clk    (clk),
      .i_data (w_sbox_in),
      .o_data (w_sbox_out)
   );

   // The S-box answer seen while issuing byte k belongs to byte k-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx        <= 2'd0;
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         r_hold       <= 32'd0;
         r_result     <= 24'd0;
         r_rsp0_valid <= 1'b0;
         r_rsp0_word  <= 32'd0;
         r_rsp1_valid <= 1'b0;
         r_rsp1_word  <= 32'd0;
      end else begin
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_hold       <= w_grant1 ? bus.req1_word : bus.req0_word;
                  r_owner      <= w_grant1;
                  r_last_grant <= w_grant1;
                  r_idx        <= 2'd0;
               end
            end
            S_ISSUE: begin
               r_idx <= r_idx + 2'd1;
               if (r_idx != 2'd0)
                  r_result[{r_idx - 2'd1, 3'b000} +: 8] <= w_sbox_out;
            end
            S_DRAIN: begin
               if (r_owner) begin
                  r_rsp1_valid <= 1'b1;
                  r_rsp1_word  <= {w_sbox_out, r_result};
               end else begin
                  r_rsp0_valid <= 1'b1;
                  r_rsp0_word  <= {w_sbox_out, r_result};
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req0_ready = w_rdy0;
   assign bus.req1_ready = w_rdy1;
   assign bus.rsp0_valid = r_rsp0_valid;
   assign bus.rsp0_word  = r_rsp0_word;
   assign bus.rsp1_valid = r_rsp1_valid;
   assign bus.rsp1_word  = r_rsp1_word;
   assign busy           = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_sbox_word_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sbox_word_arbiter
// Brief   : Directed scoreboard bench for both arbitration modes.
// Rev     : 1.0
// ============================================================================
module tb_sbox_word_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy_a;
   logic busy_b;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [63:0] sb [4][$];
   logic [31:0] last_rsp [4];

   sbox_word_arbiter_if ia ();
   sbox_word_arbiter_if ib ();

   sbox_word_arbiter #(.FIXED_PRIO(1'b0)) u_dut_a (.clk(clk), .rst(rst), .bus(ia), .busy(busy_a));
   sbox_word_arbiter #(.FIXED_PRIO(1'b1)) u_dut_b (.clk(clk), .rst(rst), .bus(ib), .busy(busy_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'd0;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   // Multiplicative inverse in GF(2^8) followed by the AES affine map.
   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'd0;
      for (int k = 1; k < 256; k++)
         if (gmul(x, k[7:0]) == 8'd1) inv = k[7:0];
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] word_ref(input logic [31:0] w);
      return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic mon(input int id, input logic v, input logic r, input logic [31:0] w,
                      input logic rv, input logic [31:0] rw);
      logic [63:0] e;
      if (rv) begin
         chk($sformatf("rsp_pending%0d", id), 64'(sb[id].size() != 0), 64'd1);
         if (sb[id].size() != 0) begin
            e = sb[id].pop_front();
            chk($sformatf("rsp_word%0d", id), 64'(rw), 64'(e[31:0]));
            chk($sformatf("rsp_cycle%0d", id), 64'(cyc), 64'(e[63:32]));
            last_rsp[id] = e[31:0];
         end
      end else begin
         chk($sformatf("rsp_hold%0d", id), 64'(rw), 64'(last_rsp[id]));
      end
      if (v && r) sb[id].push_back({cyc + 32'd6, word_ref(w)});
   endtask

   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            sb[i].delete();
            last_rsp[i] = 32'd0;
         end
      end else begin
         mon(0, ia.req0_valid, ia.req0_ready, ia.req0_word, ia.rsp0_valid, ia.rsp0_word);
         mon(1, ia.req1_valid, ia.req1_ready, ia.req1_word, ia.rsp1_valid, ia.rsp1_word);
         mon(2, ib.req0_valid, ib.req0_ready, ib.req0_word, ib.rsp0_valid, ib.rsp0_word);
         mon(3, ib.req1_valid, ib.req1_ready, ib.req1_word, ib.rsp1_valid, ib.rsp1_word);
         chk("ready_excl_a", 64'(ia.req0_ready & ia.req1_ready), 64'd0);
         chk("ready_busy_a", 64'(busy_a & (ia.req0_ready | ia.req1_ready)), 64'd0);
         chk("ready_excl_b", 64'(ib.req0_ready & ib.req1_ready), 64'd0);
         chk("ready_busy_b", 64'(busy_b & (ib.req0_ready | ib.req1_ready)), 64'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      ia.req0_valid = 1'b0; ia.req0_word = 32'd0; ia.req1_valid = 1'b0; ia.req1_word = 32'd0;
      ib.req0_valid = 1'b0; ib.req0_word = 32'd0; ib.req1_valid = 1'b0; ib.req1_word = 32'd0;
      rst = 1'b1;
      repeat (3) step();
      chk("reset_busy", 64'(busy_a), 64'd0);
      chk("reset_rsp0_valid", 64'(ia.rsp0_valid), 64'd0);
      chk("reset_rsp0_word", 64'(ia.rsp0_word), 64'd0);
      chk("reset_rsp1_word", 64'(ia.rsp1_word), 64'd0);
      chk("reset_ready0", 64'(ia.req0_ready), 64'd0);
      rst = 1'b0;

      // Single request on port 0
      step();
      ia.req0_word = 32'h00010203; ia.req0_valid = 1'b1;
      #1 chk("t1_ready0", 64'(ia.req0_ready), 64'd1);
      step();
      ia.req0_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t1_busy", 64'(busy_a), 64'd1);
         step();
      end
      chk("t1_busy_done", 64'(busy_a), 64'd0);
      chk("t1_rsp0_valid", 64'(ia.rsp0_valid), 64'd1);
      chk("t1_rsp0_word", 64'(ia.rsp0_word), 64'h637C777B);

      // Port 1 data, accepted in the same cycle the FSM returns to IDLE
      ia.req1_word = 32'h53FF1000; ia.req1_valid = 1'b1;
      #1 chk("t2_ready1", 64'(ia.req1_ready), 64'd1);
      step();
      ia.req1_valid = 1'b0;
      repeat (5) step();
      chk("t2_rsp1_valid", 64'(ia.rsp1_valid), 64'd1);
      chk("t2_rsp1_word", 64'(ia.rsp1_word), 64'hED16CA63);
      chk("t2_rsp0_kept", 64'(ia.rsp0_word), 64'h637C777B);

      // Round-robin tie after reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      ia.req0_word = $urandom; ia.req1_word = $urandom;
      ia.req0_valid = 1'b1; ia.req1_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_ready0", 64'(ia.req0_ready), 64'((k % 2) == 0));
         chk("rr_ready1", 64'(ia.req1_ready), 64'((k % 2) == 1));
         step();
         if (k == 3) begin
            ia.req0_valid = 1'b0; ia.req1_valid = 1'b0;
         end else if ((k % 2) == 0) ia.req0_word = $urandom;
         else ia.req1_word = $urandom;
         repeat (5) step();
      end
      chk("rr_last_rsp1", 64'(ia.rsp1_valid), 64'd1);

      // Back-to-back on port 0
      ia.req0_word = $urandom; ia.req0_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("b2b_ready0", 64'(ia.req0_ready), 64'd1);
         if (k > 0) chk("b2b_rsp_with_accept", 64'(ia.rsp0_valid), 64'd1);
         step();
         if (k == 2) ia.req0_valid = 1'b0;
         else ia.req0_word = $urandom;
         repeat (5) step();
      end
      chk("b2b_last_rsp0", 64'(ia.rsp0_valid), 64'd1);

      // Reset three cycles after an accept aborts the word
      ia.req0_word = 32'hDEADBEEF; ia.req0_valid = 1'b1;
      #1 chk("rst_mid_ready0", 64'(ia.req0_ready), 64'd1);
      step();
      ia.req0_valid = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mid_busy", 64'(busy_a), 64'd0);
      chk("rst_mid_rsp0_word", 64'(ia.rsp0_word), 64'd0);
      ia.req0_word = 32'h01234567; ia.req1_word = 32'h89ABCDEF;
      ia.req0_valid = 1'b1; ia.req1_valid = 1'b1;
      #1;
      chk("rst_mid_tie0", 64'(ia.req0_ready), 64'd1);
      chk("rst_mid_tie1", 64'(ia.req1_ready), 64'd0);
      step();
      ia.req0_valid = 1'b0; ia.req1_valid = 1'b0;
      repeat (5) step();
      chk("rst_mid_rsp0", 64'(ia.rsp0_valid), 64'd1);
      step();

      // Fixed priority: requester 0 wins while it stays valid
      ib.req0_word = $urandom; ib.req1_word = 32'hCAFEF00D;
      ib.req0_valid = 1'b1; ib.req1_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("fp_ready0", 64'(ib.req0_ready), 64'd1);
         chk("fp_ready1", 64'(ib.req1_ready), 64'd0);
         step();
         ib.req0_word = $urandom;
         repeat (5) step();
      end
      ib.req0_valid = 1'b0;
      #1;
      chk("fp_ready1_free", 64'(ib.req1_ready), 64'd1);
      chk("fp_ready0_idle", 64'(ib.req0_ready), 64'd0);
      step();
      ib.req1_valid = 1'b0;
      repeat (8) step();

      for (int i = 0; i < 4; i++)
         chk($sformatf("drain_q%0d", i), 64'(sb[i].size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
